// File: rtl/exc_seq_if.sv
// Exception sequencer bundle: MEM-stage capture, COP0 link,
// bus/fetch handshake and pipeline control.
interface exc_seq_if;
  logic        mem_valid;
  logic [7:0]  mem_exc_type;
  logic [31:0] mem_pc;
  logic        mem_is_delayslot;
  logic [31:0] mem_badvaddr;
  logic        cop0_exc_en;
  logic [31:0] cop0_pc_exc;
  logic        dbus_busy;
  logic        fetch_ready;
  logic [7:0]  cp0_exc_type;
  logic [31:0] cp0_victim_pc;
  logic        cp0_is_delayslot;
  logic [31:0] cp0_badvaddr;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        timeout_err;
  logic [15:0] exc_count;

  modport slave (
    input  mem_valid, mem_exc_type, mem_pc,
    input  mem_is_delayslot, mem_badvaddr,
    input  cop0_exc_en, cop0_pc_exc,
    input  dbus_busy, fetch_ready,
    output cp0_exc_type, cp0_victim_pc,
    output cp0_is_delayslot, cp0_badvaddr,
    output flush, stall,
    output redirect_valid, redirect_pc,
    output timeout_err, exc_count
  );

  modport master (
    output mem_valid, mem_exc_type, mem_pc,
    output mem_is_delayslot, mem_badvaddr,
    output cop0_exc_en, cop0_pc_exc,
    output dbus_busy, fetch_ready,
    input  cp0_exc_type, cp0_victim_pc,
    input  cp0_is_delayslot, cp0_badvaddr,
    input  flush, stall,
    input  redirect_valid, redirect_pc,
    input  timeout_err, exc_count
  );
endinterface

// File: rtl/exc_seq_ctrl.sv
// Exception sequencer: drain data bus, flush pipe,
// then hand the COP0 target to fetch.
module exc_seq_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst_n,
  exc_seq_if.slave bus
);

  localparam logic [7:0] FcC = 8'(FLUSH_CYCLES);
  localparam logic [7:0] DtC = 8'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, DRAIN, FLUSH, REDIR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] exc_cnt_q, exc_cnt_d;
  logic        tout_q, tout_d;
  logic        flush, stall, rv;
  logic [7:0]  cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cnt_q     <= '0;
      exc_cnt_q <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      exc_cnt_q <= exc_cnt_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    exc_cnt_d = exc_cnt_q;
    tout_d    = tout_q;
    flush     = 1'b0;
    stall     = 1'b0;
    rv        = 1'b0;
    unique case (state_q)
      IDLE: ;
      DRAIN: begin
        flush = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (!bus.dbus_busy) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (cnt_inc == DtC) begin
          state_d = FLUSH;
          cnt_d   = '0;
          tout_d  = 1'b1;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_inc == FcC) begin
          state_d = REDIR;
          cnt_d   = '0;
        end
      end
      REDIR: begin
        stall = 1'b1;
        rv    = 1'b1;
        if (bus.fetch_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A newly taken event restarts the sequence from any state
    if (bus.cop0_exc_en) begin
      flush    = 1'b1;
      rv       = 1'b0;
      target_d = bus.cop0_pc_exc;
      cnt_d    = '0;
      state_d  = bus.dbus_busy ? DRAIN : FLUSH;
      if (exc_cnt_q != 16'hFFFF)
        exc_cnt_d = exc_cnt_q + 16'd1;
    end
  end

  logic idle;
  assign idle = (state_q == IDLE);

  assign bus.flush          = flush & rst_n;
  assign bus.stall          = stall & rst_n;
  assign bus.redirect_valid = rv & rst_n;
  assign bus.redirect_pc    = bus.redirect_valid ? target_q : '0;
  assign bus.timeout_err    = tout_q;
  assign bus.exc_count      = exc_cnt_q;

  assign bus.cp0_exc_type =
    (idle && bus.mem_valid) ? bus.mem_exc_type : '0;
  assign bus.cp0_victim_pc    = idle ? bus.mem_pc : target_q;
  assign bus.cp0_is_delayslot = idle & bus.mem_is_delayslot;
  assign bus.cp0_badvaddr     = idle ? bus.mem_badvaddr : '0;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Directed bench for exc_seq_ctrl: default instance plus a
// short-timeout instance for the drain watchdog.
module tb_exc_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exc_seq_if ia();
  exc_seq_if ib();

  exc_seq_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(ia));
  exc_seq_ctrl #(.DRAIN_TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  int n_chk = 0;
  int n_err = 0;
  int nf, nr, ns, tf, tr;
  logic [31:0] rpc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    ia.mem_valid = 0; ia.mem_exc_type = 0; ia.mem_pc = 0;
    ia.mem_is_delayslot = 0; ia.mem_badvaddr = 0;
    ia.cop0_exc_en = 0; ia.cop0_pc_exc = 0;
    ia.dbus_busy = 0; ia.fetch_ready = 0;
    ib.mem_valid = 0; ib.mem_exc_type = 0; ib.mem_pc = 0;
    ib.mem_is_delayslot = 0; ib.mem_badvaddr = 0;
    ib.cop0_exc_en = 0; ib.cop0_pc_exc = 0;
    ib.dbus_busy = 0; ib.fetch_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_flush", 32'(ia.flush), 0);
    chk("rst_rv", 32'(ia.redirect_valid), 0);
    chk("rst_cnt", 32'(ia.exc_count), 0);
    nx();
    rst_n = 1;
  endtask

  task automatic trig(input logic [7:0] et,
                      input logic [31:0] tgt,
                      input logic busy);
    ia.mem_valid = 1; ia.mem_exc_type = et;
    ia.mem_pc = 32'h8000_0100;
    ia.cop0_exc_en = 1; ia.cop0_pc_exc = tgt;
    ia.dbus_busy = busy;
  endtask

  initial begin
    clr();
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(ia.stall), 0);
    chk("rst_rpc", ia.redirect_pc, 0);
    chk("rst_tout", 32'(ia.timeout_err), 0);
    nx();
    rst_n = 1;

    // basic exception, no drain
    trig(8'h02, 32'hBFC0_0380, 0);
    ia.fetch_ready = 1;
    #1;
    chk("t1_flush0", 32'(ia.flush), 1);
    chk("t1_cp0type", 32'(ia.cp0_exc_type), 32'h02);
    chk("t1_victim", ia.cp0_victim_pc, 32'h8000_0100);
    nx();
    ia.cop0_exc_en = 0;
    nf = 0; nr = 0; rpc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 0) chk("t1_cp0type_busy", 32'(ia.cp0_exc_type), 0);
      nf += int'(ia.flush);
      if (ia.redirect_valid) begin nr++; rpc = ia.redirect_pc; end
      nx();
    end
    chk("t1_nflush", nf + 1, 3);
    chk("t1_nrv", nr, 1);
    chk("t1_rpc", rpc, 32'hBFC0_0380);
    chk("t1_cnt", 32'(ia.exc_count), 1);
    chk("t1_idle_rpc", ia.redirect_pc, 0);
    clr();
    do_reset();

    // drain with dbus busy for 5 cycles
    trig(8'h02, 32'hBFC0_0380, 1);
    ia.fetch_ready = 1;
    nx();
    ia.cop0_exc_en = 0;
    nf = 0; nr = 0;
    for (int i = 0; i < 12; i++) begin
      ia.dbus_busy = (i < 4);
      #1;
      nf += int'(ia.flush);
      nr += int'(ia.redirect_valid);
      nx();
    end
    chk("t2_nflush", nf + 1, 8);
    chk("t2_nrv", nr, 1);
    chk("t2_tout", 32'(ia.timeout_err), 0);
    clr();
    do_reset();

    // stuck bus on the short-timeout instance
    ib.cop0_exc_en = 1; ib.cop0_pc_exc = 32'hBFC0_0380;
    ib.dbus_busy = 1; ib.fetch_ready = 1;
    #1;
    chk("t3_flush0", 32'(ib.flush), 1);
    nx();
    ib.cop0_exc_en = 0;
    tf = -1; tr = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ib.timeout_err && tf < 0) tf = i;
      if (ib.redirect_valid && tr < 0) tr = i;
      nx();
    end
    chk("t3_tout_at", tf, 4);
    chk("t3_rv_at", tr, 6);
    chk("t3_sticky", 32'(ib.timeout_err), 1);
    clr();
    do_reset();

    // eret then interrupt taken during flush
    trig(8'h20, 32'h8000_1000, 0);
    ia.fetch_ready = 1;
    #1;
    chk("t4_cp0type", 32'(ia.cp0_exc_type), 32'h20);
    nx();
    ia.mem_valid = 0;
    ia.cop0_pc_exc = 32'hBFC0_0380;
    #1;
    chk("t4_victim", ia.cp0_victim_pc, 32'h8000_1000);
    chk("t4_flush", 32'(ia.flush), 1);
    nx();
    ia.cop0_exc_en = 0;
    nr = 0; rpc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ia.redirect_valid) begin nr++; rpc = ia.redirect_pc; end
      nx();
    end
    chk("t4_nrv", nr, 1);
    chk("t4_rpc", rpc, 32'hBFC0_0380);
    chk("t4_cnt", 32'(ia.exc_count), 2);
    clr();
    do_reset();

    // fetch back-pressure in redirect
    trig(8'h02, 32'hBFC0_0380, 0);
    nx();
    ia.cop0_exc_en = 0;
    nr = 0; ns = 0;
    for (int i = 0; i < 10; i++) begin
      ia.fetch_ready = (nr == 3);
      #1;
      if (ia.redirect_valid) begin
        nr++;
        ns += int'(ia.stall);
        chk("t5_rpc", ia.redirect_pc, 32'hBFC0_0380);
      end
      nx();
    end
    chk("t5_nrv", nr, 4);
    chk("t5_nstall", ns, 4);
    clr();
    do_reset();

    // reset pulse during flush
    trig(8'h02, 32'hBFC0_0380, 0);
    ia.fetch_ready = 1;
    nx();
    clr();
    ia.fetch_ready = 1;
    #1;
    chk("t6_inflush", 32'(ia.flush), 1);
    rst_n = 0;
    #1;
    chk("t6_flush", 32'(ia.flush), 0);
    chk("t6_stall", 32'(ia.stall), 0);
    chk("t6_cnt", 32'(ia.exc_count), 0);
    nx();
    rst_n = 1;
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      nr += int'(ia.redirect_valid);
      nx();
    end
    chk("t6_nrv", nr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/exc_seq_ctrl.md
EXC_SEQ_CTRL -- requirements
Module: exc_seq_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: cycles flush is held after drain completes (range 1..15).
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 255: maximum cycles spent waiting for dbus_busy to clear (range 1..255).
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_valid  in  1  MEM-stage instruction is valid.
REQ-006 SHALL have port mem_exc_type  in  8  MEM-stage exception vector (COP0 exc_type encoding; bit5 = eret).
REQ-007 SHALL have port mem_pc  in  32  MEM-stage instruction PC.
REQ-008 SHALL have port mem_is_delayslot  in  1  MEM-stage instruction is in a delay slot.
REQ-009 SHALL have port mem_badvaddr  in  32  MEM-stage faulting data address.
REQ-010 SHALL have port cop0_exc_en  in  1  COP0 exception/interrupt taken this cycle.
REQ-011 SHALL have port cop0_pc_exc  in  32  COP0 redirect target (vector or EPC).
REQ-012 SHALL have port dbus_busy  in  1  data-bus transaction outstanding.
REQ-013 SHALL have port fetch_ready  in  1  fetch unit accepts redirect.
REQ-014 SHALL have ports cp0_exc_type (out 8), cp0_victim_pc (out 32), cp0_is_delayslot (out 1), cp0_badvaddr (out 32): COP0 exception inputs.
REQ-015 SHALL have outputs flush (1, kill IF..MEM), stall (1, freeze PC/IF), redirect_valid (1), redirect_pc (32), timeout_err (1, sticky), exc_count (16, taken events).

Function
REQ-016 SHALL implement states IDLE, DRAIN, FLUSH, REDIRECT.
REQ-017 In IDLE, cp0_exc_type SHALL equal mem_valid ? mem_exc_type : 0, combinationally; cp0_victim_pc = mem_pc; cp0_is_delayslot = mem_is_delayslot; cp0_badvaddr = mem_badvaddr.
REQ-018 Outside IDLE, cp0_exc_type SHALL be 0, cp0_victim_pc = target register, cp0_is_delayslot = 0, cp0_badvaddr = 0, so COP0 sees each exception for exactly one cycle.
REQ-019 In IDLE with cop0_exc_en=1: flush=1 in the same cycle; target <= cop0_pc_exc; exc_count += 1 (saturating at 16'hFFFF); next state DRAIN if dbus_busy=1, else FLUSH.
REQ-020 DRAIN: flush=1, stall=1; drain counter increments each cycle; exits to FLUSH when dbus_busy=0 or counter reaches DRAIN_TIMEOUT; timeout exit sets timeout_err=1 (cleared only by reset).
REQ-021 FLUSH: flush=1, stall=1 for exactly FLUSH_CYCLES cycles, then REDIRECT.
REQ-022 REDIRECT: flush=0, stall=1, redirect_valid=1, redirect_pc=target; redirect_pc stable while redirect_valid=1; on fetch_ready=1 transfer occurs, next state IDLE, redirect_valid=0 next cycle.
REQ-023 In DRAIN/FLUSH/REDIRECT, cop0_exc_en=1 (interrupt taken after eret clears EXL) SHALL reload target with cop0_pc_exc, increment exc_count, restart the sequence at DRAIN/FLUSH per dbus_busy, and drop redirect_valid; a same-cycle fetch_ready handshake is cancelled.
REQ-024 In IDLE with cop0_exc_en=0: flush=0, stall=0, redirect_valid=0.
REQ-025 Drain and flush counters SHALL clear on every entry to DRAIN/FLUSH.
REQ-026 redirect_pc SHALL be 0 whenever redirect_valid=0.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE; target, counters, exc_count=0; timeout_err=0; flush, stall, redirect_valid=0; redirect_pc=0.
REQ-028 Reset asserted mid-sequence SHALL abandon the sequence with no redirect issued after release.

Verification
REQ-029 mem_valid=1, mem_exc_type=8'h02, cop0_exc_en=1, cop0_pc_exc=32'hBFC00380, dbus_busy=0, fetch_ready=1 -> flush 3 cycles (IDLE+2 FLUSH), redirect_valid 1 cycle with redirect_pc=32'hBFC00380, exc_count=1.
REQ-030 Same as 029, dbus_busy=1 for 5 cycles -> flush for 1+5+2 cycles, then redirect; timeout_err=0.
REQ-031 dbus_busy stuck at 1, DRAIN_TIMEOUT=4 -> FLUSH entered after 4 DRAIN cycles, timeout_err=1 thereafter.
REQ-032 Eret (exc_type=8'h20, pc_exc=32'h80001000), then cop0_exc_en=1 in FLUSH with pc_exc=32'hBFC00380 -> redirect_pc=32'hBFC00380, cp0_victim_pc=32'h80001000 on that cycle, exc_count=2.
REQ-033 fetch_ready=0 for 3 cycles in REDIRECT -> redirect_valid and redirect_pc held 4 cycles, stall=1 throughout.
REQ-034 rst_n pulsed low during FLUSH -> all outputs 0 immediately, no redirect_valid after release.
